// File: rtl/mbscore_int_ctrl.sv
// mbscore_int_ctrl: fixed-priority, edge-latched interrupt controller with a req/ack/eoi handshake to the core.
// Define MBS_INT_SYNC_EN to pass irq_in through a two-flop synchronizer before edge detection.
module mbscore_int_ctrl #(
  parameter int NUM_IRQ   = 8,
  parameter int VEC_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_IRQ-1:0]   irq_in,
  input  logic                 en_we,
  input  logic [NUM_IRQ-1:0]   en_wdata,
  input  logic                 gie_in,
  input  logic                 int_ack,
  input  logic                 int_eoi,
  output logic                 int_req,
  output logic [VEC_WIDTH-1:0] int_vec,
  output logic                 in_service,
  output logic [NUM_IRQ-1:0]   pending_out
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state;
  logic [NUM_IRQ-1:0] irq_s, irq_prev, pending, en, cand, clr;
  logic [VEC_WIDTH-1:0] win;
`ifdef MBS_INT_SYNC_EN
  logic [NUM_IRQ-1:0] sync0, sync1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= irq_in;
      sync1 <= sync0;
    end
  assign irq_s = sync1;
`else
  assign irq_s = irq_in;
`endif
  assign cand = pending & en;
  // a fresh edge on the acked line is OR'ed in after the clear, so set wins
  assign clr = (state == REQ && int_ack) ? NUM_IRQ'(1) << int_vec : '0;
  assign pending_out = pending;
  always_comb begin
    win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (cand[i]) win = VEC_WIDTH'(i);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      irq_prev   <= '0;
      pending    <= '0;
      en         <= '0;
      state      <= IDLE;
      int_req    <= 1'b0;
      int_vec    <= '0;
      in_service <= 1'b0;
    end else begin
      irq_prev <= irq_s;
      pending  <= (pending & ~clr) | (irq_s & ~irq_prev);
      if (en_we) en <= en_wdata;
      case (state)
        IDLE:
          if (gie_in && |cand) begin
            int_vec <= win;
            int_req <= 1'b1;
            state   <= REQ;
          end
        REQ:
          if (int_ack) begin
            int_req    <= 1'b0;
            in_service <= 1'b1;
            state      <= SERVICE;
          end
        SERVICE:
          if (int_eoi) begin
            in_service <= 1'b0;
            state      <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mbscore_int_ctrl.sv
// tb_mbscore_int_ctrl: scoreboard bench for mbscore_int_ctrl; expected vectors are queued when edges are driven and popped on each grant.
module tb_mbscore_int_ctrl;
  localparam int N = 8;
  localparam int V = 3;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] irq_in = '0, en_wdata = '0, pending_out;
  logic en_we = 1'b0, gie_in = 1'b0, int_ack = 1'b0, int_eoi = 1'b0;
  logic int_req, in_service;
  logic [V-1:0] int_vec;
  logic [V-1:0] exp_q[$];
  logic [V-1:0] e;
  int checks = 0, errors = 0;
  bit ok;

  mbscore_int_ctrl #(.NUM_IRQ(N), .VEC_WIDTH(V)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .en_we(en_we), .en_wdata(en_wdata),
    .gie_in(gie_in), .int_ack(int_ack), .int_eoi(int_eoi), .int_req(int_req),
    .int_vec(int_vec), .in_service(in_service), .pending_out(pending_out)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      got = int_req;
    end
  endtask

  task automatic pulse_edge(input logic [N-1:0] m);
    irq_in = m;
    tick();
    irq_in = '0;
  endtask

  task automatic ack_eoi();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    int_eoi = 1'b1;
    tick();
    int_eoi = 1'b0;
  endtask

  task automatic grant_check(input string name);
    wait_req(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: int_req never rose within 10 cycles", name);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: grant of vec %0d with empty scoreboard", name, int_vec);
    end else begin
      e = exp_q.pop_front();
      if (int_vec !== e) begin
        errors++;
        $display("FAIL %s: int_vec got %0d want %0d", name, int_vec, e);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({int_req, int_vec, in_service, pending_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%0b vec=%0d svc=%0b pend=%h want all 0", int_req, int_vec, in_service, pending_out);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (int_req !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_req: cycle %0d int_req=%0b want 0", i, int_req);
      end
    end
  endtask

  task automatic test_single();
    en_we = 1'b1; en_wdata = 8'hFF; gie_in = 1'b1;
    tick();
    en_we = 1'b0;
    irq_in = 8'h20;
    exp_q.push_back(3'd5);
    tick();
    checks++;
    if (pending_out !== 8'h20 || int_req !== 1'b0) begin
      errors++;
      $display("FAIL single_pend: got pend=%h req=%0b want pend=20 req=0", pending_out, int_req);
    end
    irq_in = '0;
    tick();
    checks++;
    if (int_req !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: int_req=%0b want 1 one cycle after pending", int_req);
    end
    grant_check("single_vec");
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    checks++;
    if (int_req !== 1'b0 || in_service !== 1'b1 || pending_out !== 8'h00) begin
      errors++;
      $display("FAIL single_ack: got req=%0b svc=%0b pend=%h want 0 1 00", int_req, in_service, pending_out);
    end
    int_eoi = 1'b1;
    tick();
    int_eoi = 1'b0;
    checks++;
    if (in_service !== 1'b0 || int_vec !== 3'd5) begin
      errors++;
      $display("FAIL single_eoi: got svc=%0b vec=%0d want 0 5", in_service, int_vec);
    end
  endtask

  task automatic test_priority();
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd6);
    pulse_edge(8'h44);
    grant_check("prio_first");
    ack_eoi();
    tick();
    checks++;
    if (int_req !== 1'b1) begin
      errors++;
      $display("FAIL prio_back_to_back: int_req=%0b want 1 the cycle after eoi", int_req);
    end
    grant_check("prio_second");
    ack_eoi();
  endtask

  task automatic test_mask_gie();
    en_we = 1'b1; en_wdata = 8'h01;
    tick();
    en_we = 1'b0;
    pulse_edge(8'h08);
    tick(3);
    checks++;
    if (int_req !== 1'b0 || pending_out !== 8'h08) begin
      errors++;
      $display("FAIL mask_block: got req=%0b pend=%h want 0 08", int_req, pending_out);
    end
    exp_q.push_back(3'd3);
    en_we = 1'b1; en_wdata = 8'h08;
    tick();
    en_we = 1'b0;
    grant_check("mask_enable");
    ack_eoi();
    gie_in = 1'b0;
    pulse_edge(8'h08);
    tick(3);
    checks++;
    if (int_req !== 1'b0 || pending_out !== 8'h08) begin
      errors++;
      $display("FAIL gie_block: got req=%0b pend=%h want 0 08", int_req, pending_out);
    end
    exp_q.push_back(3'd3);
    gie_in = 1'b1;
    grant_check("gie_release");
    ack_eoi();
  endtask

  task automatic test_set_beats_clear();
    en_we = 1'b1; en_wdata = 8'hFF;
    tick();
    en_we = 1'b0;
    exp_q.push_back(3'd1);
    pulse_edge(8'h02);
    grant_check("sbc_first");
    int_ack = 1'b1; irq_in = 8'h02;
    tick();
    int_ack = 1'b0; irq_in = '0;
    checks++;
    if (pending_out[1] !== 1'b1 || in_service !== 1'b1 || int_req !== 1'b0) begin
      errors++;
      $display("FAIL sbc_pending: got pend=%h svc=%0b req=%0b want bit1=1 1 0", pending_out, in_service, int_req);
    end
    exp_q.push_back(3'd1);
    int_eoi = 1'b1;
    tick();
    int_eoi = 1'b0;
    grant_check("sbc_rerequest");
    ack_eoi();
  endtask

  task automatic test_stray();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    checks++;
    if (int_req !== 1'b0 || in_service !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack_idle: got req=%0b svc=%0b want 0 0", int_req, in_service);
    end
    exp_q.push_back(3'd4);
    pulse_edge(8'h10);
    grant_check("stray_grant");
    int_eoi = 1'b1; en_we = 1'b1; en_wdata = 8'h00; gie_in = 1'b0;
    tick();
    int_eoi = 1'b0; en_we = 1'b0; gie_in = 1'b1;
    checks++;
    if (int_req !== 1'b1 || int_vec !== 3'd4 || in_service !== 1'b0) begin
      errors++;
      $display("FAIL stray_eoi_req: got req=%0b vec=%0d svc=%0b want 1 4 0", int_req, int_vec, in_service);
    end
    int_ack = 1'b1; int_eoi = 1'b1;
    tick();
    int_ack = 1'b0; int_eoi = 1'b0;
    checks++;
    if (int_req !== 1'b0 || in_service !== 1'b1) begin
      errors++;
      $display("FAIL ack_eoi_together: got req=%0b svc=%0b want 0 1", int_req, in_service);
    end
    int_eoi = 1'b1;
    tick();
    int_eoi = 1'b0;
    en_we = 1'b1; en_wdata = 8'hFF;
    tick();
    en_we = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_q.push_back(3'd0);
    pulse_edge(8'h81);
    grant_check("mid_grant");
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({int_req, int_vec, in_service, pending_out} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got req=%0b vec=%0d svc=%0b pend=%h want all 0", int_req, int_vec, in_service, pending_out);
    end
    tick();
    rst_n = 1'b1;
    gie_in = 1'b1;
    tick(3);
    checks++;
    if (int_req !== 1'b0 || pending_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_clears_en: got req=%0b pend=%h want 0 00", int_req, pending_out);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask_gie();
    test_set_beats_clear();
    test_stray();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected grants never seen, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
